// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, funct3 codes and MMIO offsets for the data-memory controller
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} dmem_state_t;

  // Classification of an accepted access.
  typedef enum logic [1:0] {K_ERR, K_RAM, K_MMIO} dmem_kind_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] OFF_GPIO  = 3'd0;
  localparam logic [2:0] OFF_CYCLE = 3'd4;

  // True for undefined size codes and for half/word accesses off their natural alignment.
  function automatic logic f3_invalid(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// rtl/lane_align.sv - store lane replication / byte enables and load extraction / extension
// Ports:
//   st_off, st_size, st_data -> st_word (replicated data), st_be (byte enables)
//   ld_off, ld_f3, ld_word   -> ld_data (selected and sign/zero extended)
module lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [31:0] st_word,
  output logic [3:0]  st_be,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_f3,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_word = st_data;
    st_be   = 4'b1111;
    case (st_size)
      2'b00: begin
        st_word = {4{st_data[7:0]}};
        st_be   = 4'b0001 << st_off;
      end
      2'b01: begin
        st_word = {2{st_data[15:0]}};
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_word = st_data;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - req/ready data-memory controller with sized accesses, wait states and MMIO
// Ports:
//   CLK, RESET_N                 clock, async active-low reset
//   req, we, funct3, addr, wdata core request side
//   rdata, ready, err            core response side (one-cycle pulses)
//   ram_*                        synchronous RAM interface (1-cycle read latency)
//   gpio_out                     GPIO register
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int                DEPTH       = 1024,
  parameter int                ADDR_W      = 32,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 32'h8000_0000,
  parameter int                GPIO_W      = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     req,
  input  logic                     we,
  input  logic [2:0]               funct3,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  output logic [3:0]               ram_be,
  output logic                     ram_we,
  output logic                     ram_re,
  input  logic [31:0]              ram_rdata,
  output logic [GPIO_W-1:0]        gpio_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(4 * DEPTH);
  localparam logic [ADDR_W:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [ADDR_W:0] MMIO_HI = MMIO_LO + (ADDR_W+1)'(8);
  localparam logic [3:0]      WS_LAST = 4'(WAIT_STATES - 1);

  dmem_state_t state;
  dmem_kind_t  kind, kind_in;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic [31:0] hold;
  logic [3:0]  wcnt;
  logic [31:0] cycle;

  logic        in_ram, in_mmio, accept, ram_strobe;
  logic [31:0] st_word, ld_word, ld_data;
  logic [3:0]  st_be;

  assign in_ram  = {1'b0, addr} < RAM_END;
  assign in_mmio = ({1'b0, addr} >= MMIO_LO) && ({1'b0, addr} < MMIO_HI);

  always_comb begin
    kind_in = K_MMIO;
    if (f3_invalid(funct3, addr[1:0]) || !(in_ram || in_mmio)) kind_in = K_ERR;
    else if (in_ram)                                          kind_in = K_RAM;
  end

  // RAM strobes are combinational in the accept cycle; RESET_N gating keeps them low during reset.
  assign accept     = RESET_N && (state == IDLE) && req;
  assign ram_strobe = accept && (kind_in == K_RAM);
  assign ram_we     = ram_strobe && we;
  assign ram_re     = ram_strobe && !we;
  assign ram_addr   = ram_strobe ? addr[AW+1:2] : '0;
  assign ram_wdata  = ram_we ? st_word : '0;
  assign ram_be     = ram_we ? st_be : '0;

  // With no wait states the RAM word arrives in the RESP cycle itself, so it bypasses the hold register.
  assign ld_word = (kind == K_RAM && WAIT_STATES == 0) ? ram_rdata : hold;
  assign rdata   = (ready && !lat_we) ? ld_data : '0;

  lane_align u_lane_align (
    .st_off  (addr[1:0]),
    .st_size (funct3[1:0]),
    .st_data (wdata),
    .st_word (st_word),
    .st_be   (st_be),
    .ld_off  (lat_off),
    .ld_f3   (lat_f3),
    .ld_word (ld_word),
    .ld_data (ld_data)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      kind     <= K_ERR;
      lat_we   <= 1'b0;
      lat_f3   <= 3'd0;
      lat_off  <= 2'd0;
      hold     <= '0;
      wcnt     <= '0;
      cycle    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      gpio_out <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            kind    <= kind_in;
            lat_we  <= we;
            lat_f3  <= funct3;
            lat_off <= addr[1:0];
            if (kind_in == K_MMIO) begin
              hold <= addr[2] ? cycle : 32'(gpio_out);
              if (we && addr[2:0] == OFF_GPIO) begin
                for (int i = 0; i < GPIO_W; i++)
                  if (st_be[i/8]) gpio_out[i] <= st_word[i];
              end
            end
            if (kind_in == K_RAM && WAIT_STATES != 0) begin
              state <= RAM_WAIT;
              wcnt  <= WS_LAST;
            end else begin
              state <= RESP;
              ready <= (kind_in != K_ERR);
              err   <= (kind_in == K_ERR);
            end
          end
        end
        RAM_WAIT: begin
          // RAM data is valid only in the first cycle after the read strobe.
          if (wcnt == WS_LAST) hold <= ram_rdata;
          if (wcnt == 4'd0) begin
            state <= RESP;
            ready <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl (WAIT_STATES 0 and 3)
module tb_dmem_ctrl;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;

  logic [31:0] rdata0, rdata1, ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;
  logic        ready0, ready1, err0, err1, ram_we0, ram_we1, ram_re0, ram_re1;
  logic [9:0]  ram_addr0, ram_addr1;
  logic [3:0]  ram_be0, ram_be1;
  logic [7:0]  gpio0, gpio1;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  int          we_cnt0 = 0, re_cnt0 = 0, we_cnt1 = 0, re_cnt1 = 0;
  logic [3:0]  last_be0 = 4'd0;
  logic [31:0] last_wdata0 = 32'd0;
  logic [9:0]  last_addr0 = 10'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .req(req0), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_be(ram_be0), .ram_we(ram_we0), .ram_re(ram_re0),
    .ram_rdata(ram_rdata0), .gpio_out(gpio0)
  );

  dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(3)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .req(req1), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .ready(ready1), .err(err1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_be(ram_be1), .ram_we(ram_we1), .ram_re(ram_re1),
    .ram_rdata(ram_rdata1), .gpio_out(gpio1)
  );

  always @(posedge clk) begin
    if (ram_we0) begin
      for (int b = 0; b < 4; b++) if (ram_be0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
      we_cnt0 <= we_cnt0 + 1;
      last_be0 <= ram_be0;
      last_wdata0 <= ram_wdata0;
      last_addr0 <= ram_addr0;
    end
    if (ram_re0) begin
      ram_rdata0 <= mem0[ram_addr0];
      re_cnt0 <= re_cnt0 + 1;
    end
    if (ram_we1) begin
      for (int b = 0; b < 4; b++) if (ram_be1[b]) mem1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
      we_cnt1 <= we_cnt1 + 1;
    end
    if (ram_re1) begin
      ram_rdata1 <= mem1[ram_addr1];
      re_cnt1 <= re_cnt1 + 1;
    end
  end

  // Starts in a cycle just after a posedge; returns #1 after the posedge that ends the response cycle.
  task automatic access(input int sel, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic rdy,
                        output logic er, output int lat);
    we = w; funct3 = f3; addr = a; wdata = d;
    if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
    rd = 32'd0; rdy = 1'b0; er = 1'b0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel == 0 ? (ready0 | err0) : (ready1 | err1)) begin
        rd  = (sel == 0) ? rdata0 : rdata1;
        rdy = (sel == 0) ? ready0 : ready1;
        er  = (sel == 0) ? err0 : err1;
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({rdata0, ready0, err0, ram_we0, ram_re0, ram_be0, ram_addr0, ram_wdata0, gpio0} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdata=%h ready=%b err=%b gpio=%h, want all zero", rdata0, ready0, err0, gpio0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic rdy, er; int lat, wc;
    wc = we_cnt0;
    access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, rdy, er, lat);
    total++;
    if ({rdy, er, lat, rd} !== {1'b1, 1'b0, 32'd1, 32'd0}) begin
      bad++; $display("FAIL sw_resp: got rdy=%b err=%b lat=%0d rdata=%h, want 1 0 1 0", rdy, er, lat, rd);
    end
    total++;
    if ({last_be0, last_addr0, we_cnt0 - wc} !== {4'b1111, 10'd4, 32'd1}) begin
      bad++; $display("FAIL sw_strobe: got be=%b addr=%0d pulses=%0d, want 1111 4 1", last_be0, last_addr0, we_cnt0 - wc);
    end
    access(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, rdy, er, lat);
    total++;
    if ({rdy, lat, rd} !== {1'b1, 32'd1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL lw_resp: got rdy=%b lat=%0d rdata=%h, want 1 1 deadbeef", rdy, lat, rd);
    end
  endtask

  task automatic test_extend;
    logic [31:0] rd; logic rdy, er; int lat;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    access(0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, rd, rdy, er, lat);
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b0, f3s[i], as[i], 32'd0, rd, rdy, er, lat);
      total++;
      if ({rdy, rd} !== {1'b1, exp[i]}) begin
        bad++; $display("FAIL extend_%0d: got rdy=%b rdata=%h, want 1 %h", i, rdy, rd, exp[i]);
      end
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic rdy, er; int lat;
    access(0, 1'b1, 3'b010, 32'h20, 32'h11223344, rd, rdy, er, lat);
    access(0, 1'b1, 3'b000, 32'h21, 32'h000000AA, rd, rdy, er, lat);
    total++;
    if ({last_be0, last_wdata0} !== {4'b0010, 32'hAAAAAAAA}) begin
      bad++; $display("FAIL sb_lanes: got be=%b wdata=%h, want 0010 aaaaaaaa", last_be0, last_wdata0);
    end
    access(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, rdy, er, lat);
    total++;
    if (rd !== 32'h1122AA44) begin
      bad++; $display("FAIL sb_merge: got %h, want 1122aa44", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic rdy, er; int lat, wc, rc;
    logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b010, 3'b011};
    logic [31:0] as  [4] = '{32'h11, 32'h22, 32'h1000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      wc = we_cnt0; rc = re_cnt0;
      access(0, 1'b0, f3s[i], as[i], 32'd0, rd, rdy, er, lat);
      total++;
      if ({er, rdy, lat, rd, we_cnt0 - wc, re_cnt0 - rc} !== {1'b1, 1'b0, 32'd1, 32'd0, 32'd0, 32'd0}) begin
        bad++;
        $display("FAIL err_%0d: got err=%b rdy=%b lat=%0d rdata=%h strobes=%0d/%0d, want 1 0 1 0 0/0",
                 i, er, rdy, lat, rd, we_cnt0 - wc, re_cnt0 - rc);
      end
    end
  endtask

  task automatic test_mmio;
    logic [31:0] rd, c1, c2; logic rdy, er; int lat;
    access(0, 1'b1, 3'b010, MB, 32'h5A, rd, rdy, er, lat);
    total++;
    if ({rdy, lat, gpio0} !== {1'b1, 32'd1, 8'h5A}) begin
      bad++; $display("FAIL gpio_sw: got rdy=%b lat=%0d gpio=%h, want 1 1 5a", rdy, lat, gpio0);
    end
    access(0, 1'b1, 3'b000, MB + 32'd1, 32'h77, rd, rdy, er, lat);
    access(0, 1'b1, 3'b010, MB + 32'd4, 32'h0, rd, rdy, er, lat);
    total++;
    if ({rdy, gpio0} !== {1'b1, 8'h5A}) begin
      bad++; $display("FAIL gpio_masked: got rdy=%b gpio=%h, want 1 5a", rdy, gpio0);
    end
    access(0, 1'b0, 3'b100, MB, 32'd0, rd, rdy, er, lat);
    total++;
    if (rd !== 32'h5A) begin
      bad++; $display("FAIL gpio_lbu: got %h, want 0000005a", rd);
    end
    access(0, 1'b0, 3'b010, MB + 32'd4, 32'd0, c1, rdy, er, lat);
    repeat (8) @(posedge clk);
    #1;
    access(0, 1'b0, 3'b010, MB + 32'd4, 32'd0, c2, rdy, er, lat);
    total++;
    if (c2 - c1 !== 32'd10) begin
      bad++; $display("FAIL cycle_delta: got %0d, want 10", c2 - c1);
    end
    access(0, 1'b0, 3'b010, MB + 32'd8, 32'd0, rd, rdy, er, lat);
    total++;
    if ({er, rdy} !== 2'b10) begin
      bad++; $display("FAIL mmio_range: got err=%b rdy=%b, want 1 0", er, rdy);
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; logic rdy, er; int lat, rc, seen;
    access(1, 1'b1, 3'b010, 32'h40, 32'h12345678, rd, rdy, er, lat);
    total++;
    if ({rdy, lat} !== {1'b1, 32'd4}) begin
      bad++; $display("FAIL ws_sw_lat: got rdy=%b lat=%0d, want 1 4", rdy, lat);
    end
    // Load with req toggling during the wait: ready only at accept+4, single read strobe.
    rc = re_cnt1; seen = 0;
    we = 1'b0; funct3 = 3'b010; addr = 32'h40; req1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 6; i++) begin
      req1 = (i == 2 || i == 4);
      @(negedge clk);
      if (ready1) begin
        seen = seen + i * 16;
        rd = rdata1;
      end
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    total++;
    if ({seen, rd, re_cnt1 - rc} !== {32'd64, 32'h12345678, 32'd1}) begin
      bad++; $display("FAIL ws_lw: got seen_code=%0d rdata=%h reads=%0d, want 64 12345678 1", seen, rd, re_cnt1 - rc);
    end
    // Reset two cycles after accept: the response is discarded.
    seen = 0;
    req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({rdata1, ready1, err1, ram_we1, ram_re1, ram_be1, ram_addr1, ram_wdata1, gpio1} !== '0) begin
      bad++; $display("FAIL ws_reset_outputs: got rdata=%h ready=%b err=%b, want all zero", rdata1, ready1, err1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready1 | err1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL ws_reset_discard: got %0d response cycles, want 0", seen);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_byte_store();
    test_errors();
    test_mmio();
    test_wait_states();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
